data_reg_bank_ctrl: RTL and testbench
=====================================

DATA_REG_BANK_CTRL -- requirements
Module: data_reg_bank_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: data width of every data port.
REQ-002 Parameter SYNC_GAP, default 1 (range 1..15): minimum address writes granted between two consecutive syncs while any req is pending.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  4  per-unit write request; req[i] held high until ack[i] is seen.
REQ-007 data0, data1, data2, data3  input  WIDTH each  write data from units 0-3.
REQ-008 syncReq  input  1  level request to load all four bank registers from the unit inputs.
REQ-009 ack  output  4  one-hot, one-cycle grant/complete pulse per unit.
REQ-010 syncAck  output  1  one-cycle pulse marking the sync cycle.
REQ-011 dataIn  output  WIDTH  bank write data.
REQ-012 address  output  2  bank write address.
REQ-013 writeAddress  output  1  bank single-register write strobe.
REQ-014 writeAll  output  1  bank load-all strobe.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 opCount  output  16  count of completed operations (address writes plus syncs).

Function
REQ-017 All outputs SHALL be registered.
REQ-018 FSM states: IDLE, WRITE, SYNC; each non-IDLE state lasts exactly one cycle.
REQ-019 Decision edge: every rising edge in any state; the next operation is chosen from req (masked by the current ack) and syncReq.
REQ-020 Masking: while ack[i]=1, req[i] SHALL be ignored at that edge, so a unit is never granted twice for one request.
REQ-021 Sync wins over writes when syncReq=1 and gapCnt>=SYNC_GAP, or when syncReq=1 and no masked req is pending; otherwise a pending write wins.
REQ-022 Write grant: unit g is the first unit with masked req set, searching from rrPtr upward modulo 4.
REQ-023 On a write grant: next state WRITE, dataIn<=data_g, address<=g, writeAddress<=1, ack<=one-hot(g), rrPtr<=g+1 mod 4, gapCnt<=gapCnt+1 (saturating at 15).
REQ-024 On a sync grant: next state SYNC, writeAll<=1, syncAck<=1, gapCnt<=0; dataIn and address hold their previous values.
REQ-025 No grant: next state IDLE; writeAddress, writeAll, ack and syncAck are 0; dataIn and address hold.
REQ-026 Back-to-back: WRITE or SYNC SHALL go directly to the next grant with no idle bubble, giving throughput of one operation per cycle.
REQ-027 writeAddress and writeAll SHALL never be high in the same cycle.
REQ-028 Latency: a request sampled at edge N produces strobe and ack high in cycle N..N+1, and the bank captures at edge N+1.
REQ-029 opCount SHALL increment by 1 on every edge that leaves WRITE or SYNC, wrapping from 0xFFFF to 0.
REQ-030 Simultaneous req=4'b1111 with rrPtr=2 SHALL give grant order 2, 3, 0, 1.
REQ-031 A req withdrawn before it is granted SHALL be dropped silently with no ack.

Reset
REQ-032 While reset=0, the block SHALL immediately clear state to IDLE, all outputs to 0, rrPtr to 0 and gapCnt to SYNC_GAP, so a sync can be granted first.
REQ-033 Reset asserted mid-WRITE or mid-SYNC SHALL abort the operation; the strobe drops asynchronously, no ack completes, and opCount is not incremented.
REQ-034 First decision edge is the first rising edge with reset=1.

Verification
REQ-035 Single write: req=4'b0100, data2=0xDEADBEEF -> next cycle writeAddress=1, address=2, dataIn=0xDEADBEEF, ack=4'b0100; following cycle all strobes 0, opCount=1.
REQ-036 Round-robin: req=4'b1111 held, each unit drops on its ack, starting from reset -> acks in order 0, 1, 2, 3 on four consecutive cycles, no bubbles, opCount=4.
REQ-037 Sync priority after reset: syncReq=1 and req=4'b0001 on the same edge -> SYNC first (writeAll=1, syncAck=1), then WRITE unit 0, then, with syncReq still 1 and SYNC_GAP=1, SYNC again.
REQ-038 Anti-starvation with SYNC_GAP=2: syncReq held high, req=4'b0011 -> sequence SYNC, W0, W1, SYNC.
REQ-039 Reset mid-op: reset=0 during a WRITE cycle -> writeAddress and ack go to 0 before the next edge, opCount stays 0, busy=0.
REQ-040 Wrap: preload opCount to 0xFFFF via 65535 operations, then one more write -> opCount=0x0000.

Source files
------------

// File: rtl/data_reg_bank_ctrl_if.sv
// Unit/bank-side bundle for data_reg_bank_ctrl: unit requests and data in,
// bank strobes, grants and status out.
interface data_reg_bank_ctrl_if #(parameter int WIDTH = 32);
  logic [3:0]       req;
  logic [WIDTH-1:0] data0, data1, data2, data3;
  logic             syncReq;
  logic [3:0]       ack;
  logic             syncAck;
  logic [WIDTH-1:0] dataIn;
  logic [1:0]       address;
  logic             writeAddress;
  logic             writeAll;
  logic             busy;
  logic [15:0]      opCount;

  modport master (
    output req, data0, data1, data2, data3, syncReq,
    input  ack, syncAck, dataIn, address, writeAddress, writeAll, busy, opCount
  );
  modport slave (
    input  req, data0, data1, data2, data3, syncReq,
    output ack, syncAck, dataIn, address, writeAddress, writeAll, busy, opCount
  );
endinterface

// File: rtl/data_reg_bank_ctrl.sv
// Round-robin arbiter between four unit writers and a load-all sync into a
// 4-entry register bank; one registered operation per cycle.
module data_reg_bank_ctrl #(
  parameter int WIDTH    = 32,
  parameter int SYNC_GAP = 1
) (
  input  logic clk,
  input  logic reset,
  data_reg_bank_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] SYNC  = 2'd2;
  localparam logic [3:0] GAP   = 4'(SYNC_GAP);

  logic [1:0]       r_state;
  logic [3:0]       r_ack;
  logic             r_sync_ack;
  logic [WIDTH-1:0] r_data_in;
  logic [1:0]       r_address;
  logic             r_wr_addr;
  logic             r_wr_all;
  logic             r_busy;
  logic [15:0]      r_op_cnt;
  logic [1:0]       r_rr;
  logic [3:0]       r_gap;

  logic [3:0]       w_masked;
  logic             w_pend;
  logic             w_sync;
  logic             w_found;
  logic [1:0]       w_grant;
  logic [WIDTH-1:0] w_data;

  always_comb begin
    // A unit being acked this cycle has not yet dropped its req.
    w_masked = bus.req & ~r_ack;
    w_pend   = |w_masked;
    w_sync   = bus.syncReq && ((r_gap >= GAP) || !w_pend);
    w_found  = 1'b0;
    w_grant  = r_rr;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && w_masked[r_rr + 2'(k)]) begin
        w_found = 1'b1;
        w_grant = r_rr + 2'(k);
      end
    end
    case (w_grant)
      2'd0:    w_data = bus.data0;
      2'd1:    w_data = bus.data1;
      2'd2:    w_data = bus.data2;
      default: w_data = bus.data3;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ack      <= '0;
      r_sync_ack <= 1'b0;
      r_data_in  <= '0;
      r_address  <= '0;
      r_wr_addr  <= 1'b0;
      r_wr_all   <= 1'b0;
      r_busy     <= 1'b0;
      r_op_cnt   <= '0;
      r_rr       <= '0;
      r_gap      <= GAP;
    end else begin
      if (r_state != IDLE) r_op_cnt <= r_op_cnt + 16'd1;
      if (w_sync) begin
        r_state    <= SYNC;
        r_wr_all   <= 1'b1;
        r_sync_ack <= 1'b1;
        r_wr_addr  <= 1'b0;
        r_ack      <= '0;
        r_busy     <= 1'b1;
        r_gap      <= '0;
      end else if (w_pend) begin
        r_state    <= WRITE;
        r_data_in  <= w_data;
        r_address  <= w_grant;
        r_wr_addr  <= 1'b1;
        r_wr_all   <= 1'b0;
        r_sync_ack <= 1'b0;
        r_ack      <= 4'b0001 << w_grant;
        r_busy     <= 1'b1;
        r_rr       <= w_grant + 2'd1;
        if (r_gap != 4'hF) r_gap <= r_gap + 4'd1;
      end else begin
        r_state    <= IDLE;
        r_wr_addr  <= 1'b0;
        r_wr_all   <= 1'b0;
        r_sync_ack <= 1'b0;
        r_ack      <= '0;
        r_busy     <= 1'b0;
      end
    end
  end

  assign bus.ack          = r_ack;
  assign bus.syncAck      = r_sync_ack;
  assign bus.dataIn       = r_data_in;
  assign bus.address      = r_address;
  assign bus.writeAddress = r_wr_addr;
  assign bus.writeAll     = r_wr_all;
  assign bus.busy         = r_busy;
  assign bus.opCount      = r_op_cnt;
endmodule

// File: tb/tb_data_reg_bank_ctrl.sv
// Directed bench: instance A (SYNC_GAP=1) and instance B (SYNC_GAP=2).
module tb_data_reg_bank_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  data_reg_bank_ctrl_if #(.WIDTH(32)) ifa ();
  data_reg_bank_ctrl_if #(.WIDTH(32)) ifb ();

  data_reg_bank_ctrl #(.WIDTH(32), .SYNC_GAP(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  data_reg_bank_ctrl #(.WIDTH(32), .SYNC_GAP(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    ifa.req = '0; ifa.syncReq = 1'b0;
    ifa.data0 = 32'h0; ifa.data1 = 32'h0; ifa.data2 = 32'h0; ifa.data3 = 32'h0;
    ifb.req = '0; ifb.syncReq = 1'b0;
    ifb.data0 = 32'hB0; ifb.data1 = 32'hB1; ifb.data2 = 32'hB2; ifb.data3 = 32'hB3;

    // reset values
    tick();
    chk("rst_ack", 32'(ifa.ack), 32'h0);
    chk("rst_busy", 32'(ifa.busy), 32'h0);
    chk("rst_opcnt", 32'(ifa.opCount), 32'h0);
    chk("rst_wa", 32'(ifa.writeAddress), 32'h0);
    chk("rst_wall", 32'(ifa.writeAll), 32'h0);
    chk("rst_data", ifa.dataIn, 32'h0);
    reset = 1'b1;

    // single write
    ifa.data2 = 32'hDEADBEEF;
    ifa.req = 4'b0100;
    tick();
    chk("sw_wa", 32'(ifa.writeAddress), 32'h1);
    chk("sw_addr", 32'(ifa.address), 32'h2);
    chk("sw_data", ifa.dataIn, 32'hDEADBEEF);
    chk("sw_ack", 32'(ifa.ack), 32'h4);
    chk("sw_busy", 32'(ifa.busy), 32'h1);
    chk("sw_wall", 32'(ifa.writeAll), 32'h0);
    ifa.req = '0;
    tick();
    chk("sw_wa_off", 32'(ifa.writeAddress), 32'h0);
    chk("sw_ack_off", 32'(ifa.ack), 32'h0);
    chk("sw_opcnt", 32'(ifa.opCount), 32'h1);
    chk("sw_idle", 32'(ifa.busy), 32'h0);

    // reset mid-write drops strobe asynchronously
    ifa.data1 = 32'h11111111;
    ifa.req = 4'b0010;
    tick();
    chk("mr_wa", 32'(ifa.writeAddress), 32'h1);
    reset = 1'b0;
    #1;
    chk("mr_wa_off", 32'(ifa.writeAddress), 32'h0);
    chk("mr_ack_off", 32'(ifa.ack), 32'h0);
    chk("mr_busy", 32'(ifa.busy), 32'h0);
    chk("mr_opcnt", 32'(ifa.opCount), 32'h0);
    ifa.req = '0;
    tick();
    reset = 1'b1;

    // round-robin from reset, no bubbles
    ifa.data0 = 32'hA0; ifa.data1 = 32'hA1; ifa.data2 = 32'hA2; ifa.data3 = 32'hA3;
    ifa.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_ack", 32'(ifa.ack), 32'h1 << i);
      chk("rr_addr", 32'(ifa.address), 32'(i));
      chk("rr_data", ifa.dataIn, 32'hA0 + 32'(i));
      ifa.req = ifa.req & ~ifa.ack;
    end
    tick();
    chk("rr_opcnt", 32'(ifa.opCount), 32'd4);
    chk("rr_idle", 32'(ifa.ack), 32'h0);

    // bring rrPtr to 2, then all four request together: 2,3,0,1
    ifa.req = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      tick();
      ifa.req = ifa.req & ~ifa.ack;
    end
    ifa.req = 4'b1111;
    tick(); chk("ord_2", 32'(ifa.ack), 32'h4); ifa.req = ifa.req & ~ifa.ack;
    tick(); chk("ord_3", 32'(ifa.ack), 32'h8); ifa.req = ifa.req & ~ifa.ack;
    tick(); chk("ord_0", 32'(ifa.ack), 32'h1); ifa.req = ifa.req & ~ifa.ack;
    tick(); chk("ord_1", 32'(ifa.ack), 32'h2); ifa.req = ifa.req & ~ifa.ack;
    tick();
    chk("ord_opcnt", 32'(ifa.opCount), 32'd10);

    // sync priority after reset, SYNC_GAP=1
    do_reset();
    ifa.req = 4'b0001;
    ifa.syncReq = 1'b1;
    tick();
    chk("sp_wall", 32'(ifa.writeAll), 32'h1);
    chk("sp_sack", 32'(ifa.syncAck), 32'h1);
    chk("sp_wa", 32'(ifa.writeAddress), 32'h0);
    chk("sp_ack", 32'(ifa.ack), 32'h0);
    tick();
    chk("sp_w0_ack", 32'(ifa.ack), 32'h1);
    chk("sp_w0_wall", 32'(ifa.writeAll), 32'h0);
    ifa.req = ifa.req & ~ifa.ack;
    tick();
    chk("sp_sync2", 32'(ifa.syncAck), 32'h1);
    chk("sp_sync2_wa", 32'(ifa.writeAddress), 32'h0);
    ifa.syncReq = 1'b0;
    tick();
    chk("sp_opcnt", 32'(ifa.opCount), 32'd3);
    chk("sp_idle", 32'(ifa.busy), 32'h0);

    // withdrawn request is dropped with no ack
    do_reset();
    ifa.syncReq = 1'b1;
    ifa.req = 4'b1000;
    tick();
    chk("wd_sync", 32'(ifa.syncAck), 32'h1);
    ifa.syncReq = 1'b0;
    ifa.req = '0;
    tick();
    chk("wd_ack", 32'(ifa.ack), 32'h0);
    chk("wd_wa", 32'(ifa.writeAddress), 32'h0);
    tick();
    chk("wd_ack2", 32'(ifa.ack), 32'h0);

    // anti-starvation on B (SYNC_GAP=2): SYNC, W0, W1, SYNC
    do_reset();
    ifb.syncReq = 1'b1;
    ifb.req = 4'b0011;
    tick();
    chk("as_sync1", 32'(ifb.syncAck), 32'h1);
    chk("as_sync1_ack", 32'(ifb.ack), 32'h0);
    tick();
    chk("as_w0", 32'(ifb.ack), 32'h1);
    chk("as_w0_data", ifb.dataIn, 32'hB0);
    ifb.req = ifb.req & ~ifb.ack;
    tick();
    chk("as_w1", 32'(ifb.ack), 32'h2);
    chk("as_w1_sack", 32'(ifb.syncAck), 32'h0);
    ifb.req = ifb.req & ~ifb.ack;
    tick();
    chk("as_sync2", 32'(ifb.syncAck), 32'h1);
    chk("as_sync2_wall", 32'(ifb.writeAll), 32'h1);
    chk("as_sync2_data", ifb.dataIn, 32'hB1);
    ifb.syncReq = 1'b0;
    tick();
    chk("as_opcnt", 32'(ifb.opCount), 32'd4);

    // opCount wrap: back-to-back syncs, then one write
    do_reset();
    ifa.syncReq = 1'b1;
    repeat (65535) tick();
    chk("wr_pre", 32'(ifa.opCount), 32'd65534);
    ifa.syncReq = 1'b0;
    ifa.req = 4'b0001;
    tick();
    chk("wr_ffff", 32'(ifa.opCount), 32'hFFFF);
    chk("wr_ack", 32'(ifa.ack), 32'h1);
    ifa.req = '0;
    tick();
    chk("wr_zero", 32'(ifa.opCount), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
